// File: rtl/serial_ck_chk.sv
// Receiver-side checker for a serial_ck waveform: measures idle delay, level widths and
// cycle count on a synchronous line and reports per-field mismatches plus timeout.
module serial_ck_chk #(
    parameter int CW  = 32,
    parameter int TMO = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          a,
    input  logic          y0,
    input  logic [7:0]    ncyc,
    input  logic [CW-1:0] n0,
    input  logic [CW-1:0] n1,
    input  logic [CW-1:0] n2,
    output logic          busy,
    output logic          done,
    output logic [3:0]    err,
    output logic [7:0]    cyc_cnt,
    output logic [CW-1:0] meas_n1,
    output logic [CW-1:0] meas_n2
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_PH1   = 3'd2,
        S_PH2   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int            TW       = $clog2(TMO + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [TW-1:0] TMO_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TMO_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    state_t        state_r, state_n;
    logic          a_q_r, a_p_r;
    logic          y0_r;
    logic [7:0]    ncyc_r;
    logic [CW-1:0] n0_r, n1_r, n2_r;
    logic [CW-1:0] cnt_r, cnt_n;
    logic [TW-1:0] tmo_r, tmo_n;
    logic [3:0]    err_r, err_n;
    logic [7:0]    cyc_r, cyc_n;
    logic [CW-1:0] mn1_r, mn1_n, mn2_r, mn2_n;
    logic          busy_r, done_r, done_n, latch_s;

    logic          edge_s, final_s, tmo_hit_s;
    logic [CW-1:0] cnt_inc_s;
    logic [TW-1:0] tmo_inc_s;
    logic [CW:0]   n0_exp_s;

    assign edge_s    = a_q_r ^ a_p_r;
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
    assign tmo_inc_s = (tmo_r == TMO_LAST) ? tmo_r : (tmo_r + TMO_ONE);
    assign tmo_hit_s = !edge_s && (tmo_r == TMO_LAST);
    assign final_s   = (cyc_r == (ncyc_r - 8'd1));
    // ARMED also counts the cycle in which go was sampled, hence the +1
    assign n0_exp_s  = {1'b0, n0_r} + {{CW{1'b0}}, 1'b1};

    // Next-state and next-output logic for the checking FSM
    always_comb begin
        state_n = state_r;
        cnt_n   = edge_s ? CNT_ONE : cnt_inc_s;
        tmo_n   = edge_s ? TMO_ZERO : tmo_inc_s;
        err_n   = err_r;
        cyc_n   = cyc_r;
        mn1_n   = mn1_r;
        mn2_n   = mn2_r;
        done_n  = 1'b0;
        latch_s = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (go) begin
                    latch_s = 1'b1;
                    cyc_n   = 8'd0;
                    tmo_n   = TMO_ZERO;
                    if (a_q_r != y0) begin
                        state_n = S_PH1;
                        err_n   = 4'b0001;
                        cnt_n   = CNT_ONE;
                    end else begin
                        state_n = S_ARMED;
                        err_n   = 4'b0000;
                        cnt_n   = CNT_ZERO;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            S_ARMED: begin
                if (a_q_r != y0_r) begin
                    state_n  = S_PH1;
                    err_n[0] = err_r[0] | ({1'b0, cnt_r} != n0_exp_s);
                end else if (tmo_hit_s) begin
                    state_n  = S_DONE;
                    err_n[3] = 1'b1;
                    done_n   = 1'b1;
                end else begin
                    state_n = state_r;
                end
            end
            S_PH1: begin
                if (edge_s) begin
                    state_n  = S_PH2;
                    mn1_n    = cnt_r;
                    err_n[1] = err_r[1] | (cnt_r != n1_r);
                end else if (tmo_hit_s) begin
                    state_n  = S_DONE;
                    err_n[3] = 1'b1;
                    done_n   = 1'b1;
                end else begin
                    state_n = state_r;
                end
            end
            S_PH2: begin
                // Last cycle closes on a full n2 level or on an early (short) edge
                if (final_s && (edge_s || (cnt_r >= n2_r))) begin
                    state_n  = S_DONE;
                    mn2_n    = cnt_r;
                    err_n[2] = err_r[2] | (cnt_r != n2_r);
                    cyc_n    = cyc_r + 8'd1;
                    done_n   = 1'b1;
                end else if (edge_s) begin
                    state_n  = S_PH1;
                    mn2_n    = cnt_r;
                    err_n[2] = err_r[2] | (cnt_r != n2_r);
                    cyc_n    = cyc_r + 8'd1;
                end else if (tmo_hit_s) begin
                    state_n  = S_DONE;
                    err_n[3] = 1'b1;
                    done_n   = 1'b1;
                end else begin
                    state_n = state_r;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State register, line sampling, expectation latch and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
            a_q_r   <= 1'b0;
            a_p_r   <= 1'b0;
            y0_r    <= 1'b0;
            ncyc_r  <= 8'd1;
            n0_r    <= CNT_ZERO;
            n1_r    <= CNT_ZERO;
            n2_r    <= CNT_ZERO;
            cnt_r   <= CNT_ZERO;
            tmo_r   <= TMO_ZERO;
            err_r   <= 4'b0000;
            cyc_r   <= 8'd0;
            mn1_r   <= CNT_ZERO;
            mn2_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            a_q_r   <= a;
            a_p_r   <= a_q_r;
            cnt_r   <= cnt_n;
            tmo_r   <= tmo_n;
            err_r   <= err_n;
            cyc_r   <= cyc_n;
            mn1_r   <= mn1_n;
            mn2_r   <= mn2_n;
            busy_r  <= (state_n == S_ARMED) || (state_n == S_PH1) || (state_n == S_PH2);
            done_r  <= done_n;
            if (latch_s) begin
                y0_r   <= y0;
                ncyc_r <= (ncyc == 8'd0) ? 8'd1 : ncyc;
                n0_r   <= n0;
                n1_r   <= n1;
                n2_r   <= n2;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;
    assign cyc_cnt = cyc_r;
    assign meas_n1 = mn1_r;
    assign meas_n2 = mn2_r;

endmodule

// File: tb/tb_serial_ck_chk.sv
// Scenario bench for serial_ck_chk: waveforms are built as bit queues, expected reports are
// queued when a check is launched and compared when done pulses.
module tb_serial_ck_chk;

    localparam int CW  = 32;
    localparam int TMO = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          go  = 1'b0;
    logic          a   = 1'b0;
    logic          y0  = 1'b0;
    logic [7:0]    ncyc = 8'd0;
    logic [CW-1:0] n0 = '0, n1 = '0, n2 = '0;
    logic          busy, done;
    logic [3:0]    err;
    logic [7:0]    cyc_cnt;
    logic [CW-1:0] meas_n1, meas_n2;

    serial_ck_chk #(.CW(CW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .go(go), .a(a), .y0(y0), .ncyc(ncyc),
        .n0(n0), .n1(n1), .n2(n2), .busy(busy), .done(done), .err(err),
        .cyc_cnt(cyc_cnt), .meas_n1(meas_n1), .meas_n2(meas_n2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    err;
        logic [7:0]    cyc;
        logic [CW-1:0] mn1;
        logic [CW-1:0] mn2;
        bit            chk_meas;
    } exp_t;

    exp_t sb[$];
    bit   wave[$];
    int   tests = 0;
    int   fails = 0;
    int   done_seen;
    int   done_step;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_lvl(input bit v, input int n);
        for (int i = 0; i < n; i++) wave.push_back(v);
    endtask

    task automatic build(input bit idle, input int d0, input int cycles, input int w1, input int w2);
        wave.delete();
        add_lvl(idle, d0);
        for (int c = 0; c < cycles; c++) begin
            add_lvl(!idle, w1);
            add_lvl(idle, w2);
        end
    endtask

    task automatic setup(input bit iy0, input logic [7:0] inc, input int i0, input int i1, input int i2);
        y0   = iy0;
        a    = iy0;
        ncyc = inc;
        n0   = CW'(i0);
        n1   = CW'(i1);
        n2   = CW'(i2);
    endtask

    task automatic push_exp(input logic [3:0] e_err, input logic [7:0] e_cyc,
                            input int e_mn1, input int e_mn2, input bit chk);
        exp_t e;
        e.err = e_err; e.cyc = e_cyc; e.mn1 = CW'(e_mn1); e.mn2 = CW'(e_mn2); e.chk_meas = chk;
        sb.push_back(e);
    endtask

    // Pulse go, play the wave, compare the queued report on done.
    // poke > 0: at that step pulse go again and change n1 (must both be ignored).
    task automatic run(input string name, input int budget, input bit rearm, input int poke);
        exp_t e;
        step();
        go = 1'b1;
        a  = y0;
        done_seen = 0;
        done_step = -1;
        for (int s = 1; s <= budget; s++) begin
            step();
            go = 1'b0;
            if (s == 5 && wave.size() > 10) begin
                tests++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL %s_busy: busy=%b required 1", name, busy);
                end
            end
            if (s == poke) begin
                go = 1'b1;
                n1 = n1 + 32'd5;
            end
            if (done === 1'b1) begin
                done_seen++;
                done_step = s;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL %s_unexpected_done: done at step %0d, no report pending", name, s);
                end else begin
                    e = sb.pop_front();
                    if (err !== e.err || cyc_cnt !== e.cyc ||
                        (e.chk_meas && (meas_n1 !== e.mn1 || meas_n2 !== e.mn2))) begin
                        fails++;
                        $display("FAIL %s_report: err=%b cyc=%0d n1=%0d n2=%0d, required err=%b cyc=%0d n1=%0d n2=%0d",
                                 name, err, cyc_cnt, meas_n1, meas_n2, e.err, e.cyc, e.mn1, e.mn2);
                    end
                end
                if (rearm) begin
                    go = 1'b1;
                    step();
                    go = 1'b0;
                    tests++;
                    if (busy !== 1'b1) begin
                        fails++;
                        $display("FAIL %s_rearm: busy=%b required 1", name, busy);
                    end
                    break;
                end
            end
            a = (s - 1 < wave.size()) ? wave[s-1] : y0;
            if (done_step >= 0 && s >= done_step + 6) break;
        end
        tests++;
        if (done_seen != 1) begin
            fails++;
            $display("FAIL %s_done_count: saw %0d done pulses, required 1", name, done_seen);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 4'b0000 || cyc_cnt !== 8'd0 ||
            meas_n1 !== '0 || meas_n2 !== '0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b err=%b cyc=%0d n1=%0d n2=%0d, required all zero",
                     busy, done, err, cyc_cnt, meas_n1, meas_n2);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_clean();
        setup(1'b1, 8'd16, 2, 3, 4);
        build(1'b1, 2, 16, 3, 4);
        push_exp(4'b0000, 8'd16, 3, 4, 1'b1);
        run("clean", 400, 1'b0, 20);
    endtask

    task automatic test_n0_err();
        setup(1'b1, 8'd16, 1, 3, 4);
        build(1'b1, 2, 16, 3, 4);
        push_exp(4'b0001, 8'd16, 3, 4, 1'b1);
        run("n0_err", 400, 1'b0, 0);
    endtask

    task automatic test_n1_err();
        setup(1'b1, 8'd16, 2, 3, 4);
        wave.delete();
        add_lvl(1'b1, 2);
        for (int c = 0; c < 16; c++) begin
            add_lvl(1'b0, (c == 4) ? 2 : 3);
            add_lvl(1'b1, 4);
        end
        push_exp(4'b0010, 8'd16, 3, 4, 1'b1);
        run("n1_err", 400, 1'b0, 0);
    endtask

    task automatic test_timeout();
        setup(1'b1, 8'd16, 2, 3, 4);
        wave.delete();
        push_exp(4'b1000, 8'd0, 0, 0, 1'b0);
        run("timeout", 1100, 1'b0, 0);
        tests++;
        if (done_step < TMO || done_step > TMO + 2) begin
            fails++;
            $display("FAIL timeout_latency: done at step %0d, required %0d..%0d", done_step, TMO, TMO + 2);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        setup(1'b1, 8'd16, 2, 3, 4);
        build(1'b1, 2, 16, 3, 4);
        seen = 0;
        step();
        go = 1'b1;
        for (int s = 1; s <= 55; s++) begin
            step();
            go = 1'b0;
            if (done === 1'b1) seen++;
            a = wave[s-1];
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        a = y0;
        tests++;
        if (busy !== 1'b0 || err !== 4'b0000 || cyc_cnt !== 8'd0 || meas_n1 !== '0 || meas_n2 !== '0) begin
            fails++;
            $display("FAIL reset_mid_state: busy=%b err=%b cyc=%0d n1=%0d n2=%0d, required all zero",
                     busy, err, cyc_cnt, meas_n1, meas_n2);
        end
        for (int s = 0; s < 40; s++) begin
            step();
            if (done === 1'b1) seen++;
        end
        tests++;
        if (seen != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_quiet: done pulses=%0d busy=%b, required 0 and 0", seen, busy);
        end
        push_exp(4'b0000, 8'd16, 3, 4, 1'b1);
        run("reset_rerun", 400, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        setup(1'b0, 8'd1, 0, 1, 1);
        build(1'b0, 0, 1, 1, 1);
        push_exp(4'b0000, 8'd1, 1, 1, 1'b1);
        run("back_to_back", 50, 1'b1, 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_clean();
        test_n0_err();
        test_n1_err();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d reports left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
